// File: rtl/ripple_add_stage_pkg.sv
// Shared definitions for the ripple-carry add stage: FSM encoding and sizing helper.
package ripple_add_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Smallest number of bits able to index 'value' distinct states.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ripple_add_stage_rca_core.sv
// Combinational n-bit ripple-carry adder built from a chain of full-adder cells.
module rca_core #(
  parameter int unsigned WIDTH = 4
) (
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p          = a[i] ^ b[i];
    assign sum[i]     = p ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (p & carry[i]);
  end

  assign c_out = carry[WIDTH];

endmodule

// File: rtl/ripple_add_stage.sv
// Handshaked operand staging and timed result capture around a ripple-carry adder,
// with an optional running-total accumulate mode.
module ripple_add_stage
  import ripple_add_stage_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CNT_W = clog2(SETTLE_CYC + 1);
  localparam int unsigned MSB   = WIDTH - 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic             cin_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic             core_ovf;
  logic             accept;
  logic             capture;

  rca_core #(.WIDTH(WIDTH)) u_core (
    .sum   (core_sum),
    .c_out (core_cout),
    .a     (opa_r),
    .b     (opb_r),
    .c_in  (cin_r)
  );

  assign core_ovf = (opa_r[MSB] == opb_r[MSB]) && (core_sum[MSB] != opa_r[MSB]);

  // Next-state and datapath load enables.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state, so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r <= '0;
      opb_r <= '0;
      cin_r <= 1'b0;
      cnt   <= '0;
      acc_r <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        opa_r <= acc_en ? acc_r : a;
        opb_r <= b;
        cin_r <= c_in;
        cnt   <= CNT_W'(SETTLE_CYC - 1);
      end else if ((state == ST_SETTLE) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        sum   <= core_sum;
        c_out <= core_cout;
        ovf   <= core_ovf;
        acc_r <= core_sum;
      end
    end
  end

endmodule

// File: tb/tb_ripple_add_stage.sv
// Scoreboard bench for ripple_add_stage: driver queues expected results, monitor checks each one presented.
module tb_ripple_add_stage;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned SETTLE_CYC = 3;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  res_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  logic prev_valid = 1'b0;
  bit   done = 1'b0;

  ripple_add_stage #(.WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each newly presented result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_valid) begin
      res_t got;
      got = '{sum: sum, c_out: c_out, ovf: ovf};
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(got), 32'hFFFF_FFFF);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("result", 32'(got), 32'(e));
      end
    end
    prev_valid = rst_n ? out_valid : 1'b0;
  end

  // One accept-to-drain transaction with out_ready held high; checks latency and in_ready return.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vc, input logic vacc, input res_t e);
    int lat;
    @(posedge clk); #1;
    a = va; b = vb; c_in = vc; acc_en = vacc; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(SETTLE_CYC));
    @(posedge clk); #1;
    chk("in_ready_after_drain", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_flags", {30'd0, in_ready, out_valid}, 32'b10);
    chk("reset_result", {27'd0, sum, c_out, ovf}, 32'd0);
    #10 rst_n = 1'b1;

    send(4'd3,  4'd5, 1'b0, 1'b0, '{sum: 4'd8, c_out: 1'b0, ovf: 1'b1});
    send(4'd15, 4'd1, 1'b0, 1'b0, '{sum: 4'd0, c_out: 1'b1, ovf: 1'b0});
    send(4'd7,  4'd0, 1'b1, 1'b0, '{sum: 4'd8, c_out: 1'b0, ovf: 1'b1});
    send(4'd2,  4'd0, 1'b0, 1'b0, '{sum: 4'd2, c_out: 1'b0, ovf: 1'b0});
    send(4'd9,  4'd3, 1'b0, 1'b1, '{sum: 4'd5, c_out: 1'b0, ovf: 1'b0});
    send(4'd1,  4'd4, 1'b0, 1'b1, '{sum: 4'd9, c_out: 1'b0, ovf: 1'b1});

    // Backpressure: 1+1 held with out_ready low while upstream keeps toggling.
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = 4'd1; b = 4'd1; c_in = 1'b0; acc_en = 1'b0; in_valid = 1'b1;
    exp_q.push_back('{sum: 4'd2, c_out: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = ~a; b = b + 4'd3;
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'(SETTLE_CYC));
    for (int i = 0; i < 6; i++) begin
      a = ~a; b = b + 4'd5; c_in = ~c_in;
      @(posedge clk); #1;
      chk("bp_hold", {26'd0, sum, c_out, ovf, in_ready, out_valid}, {26'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    a = 4'd4; b = 4'd4; c_in = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
    exp_q.push_back('{sum: 4'd8, c_out: 1'b0, ovf: 1'b1});
    @(posedge clk); #1;
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk); #1;
    chk("bp_next_accept", {30'd0, in_ready, out_valid}, 32'b00);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_latency", 32'(lat), 32'(SETTLE_CYC));
    @(posedge clk); #1;

    // Reset mid-settle discards the pending result and the accumulator.
    @(posedge clk); #1;
    a = 4'd9; b = 4'd9; c_in = 1'b1; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {30'd0, in_ready, out_valid}, 32'b10);
    chk("async_reset_result", {27'd0, sum, c_out, ovf}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {30'd0, in_ready, out_valid}, 32'b10);
    send(4'd15, 4'd6, 1'b0, 1'b1, '{sum: 4'd6, c_out: 1'b0, ovf: 1'b0});

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: run did not complete, %0d/%0d checks passed so far", passes, checks);
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/ripple_add_stage.md
# ripple_add_stage

Handshaked operand-staging and result-capture stage wrapped around an n-bit ripple-carry adder core. It accepts operand pairs from an upstream producer and registers them into the adder. It waits a fixed settle interval covering worst-case carry ripple, then captures sum, carry-out and signed overflow for a downstream consumer. An optional accumulate mode substitutes the last captured sum for operand a, giving a running total.

## Interface
- WIDTH, default 4: operand/sum width in bits; legal range 2 to 32.
- SETTLE_CYC, default 3: clocks between operand registration and result capture; minimum 1.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream has an operand set on a, b, c_in, acc_en.
- in_ready  output  1  stage can accept an operand set.
- a  input  WIDTH  operand a; ignored when acc_en=1.
- b  input  WIDTH  operand b.
- c_in  input  1  carry-in.
- acc_en  input  1  1 means use the accumulator register in place of a.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  registered sum.
- c_out  output  1  registered carry-out.
- ovf  output  1  registered two's-complement overflow.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - SETTLE: both 0; down-counter running.
  - DONE: out_valid=1, in_ready=0.
- IDLE to SETTLE when in_valid and in_ready are both high at an edge:
  - opa_r is loaded with (acc_en ? acc_r : a); opb_r with b; cin_r with c_in.
  - cnt is loaded with SETTLE_CYC-1.
- SETTLE:
  - If cnt is not 0, decrement cnt.
  - If cnt is 0, capture core outputs into sum, c_out and ovf; load acc_r with the core sum; go to DONE.
- DONE to IDLE when out_ready is high at an edge.
- While out_valid=1, sum, c_out and ovf hold stable regardless of out_ready.
- Arithmetic is modulo 2^WIDTH; c_out is bit WIDTH of opa_r + opb_r + cin_r.
- ovf = (opa_r[MSB] == opb_r[MSB]) && (sum[MSB] != opa_r[MSB]).
- acc_r updates only on capture. It is never cleared except by reset; the upstream sends acc_en=0 to start a fresh total.
- Upstream inputs are sampled only on the accept edge. Changes while in_ready=0 are ignored.

## Timing
- Reset (rst_n=0, takes effect immediately):
  - State goes to IDLE; opa_r, opb_r, cin_r, cnt, acc_r, sum, c_out and ovf are all 0.
  - out_valid=0 and in_ready=1 while rst_n=0 and after release.
- Latency: operand accepted at edge k means out_valid rises after edge k+SETTLE_CYC.
- Throughput: one result every SETTLE_CYC+2 cycles when out_ready is held at 1.
- in_ready reasserts the cycle after the out handshake edge. There is no accept in the same cycle as a result drain.
- in_ready and out_valid are pure functions of the state register; there is no combinational path from in_valid or out_ready.
- Reset during SETTLE or DONE discards the pending result and acc_r. There is no partial output.
- The adder core is combinational. Its worst-case ripple across WIDTH bits must settle within SETTLE_CYC clock periods; integration owns that constraint.

## Structure
- Shared package holds:
  - the state encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_DONE=2'd2;
  - the counter-width function clog2, used to size cnt as clog2(SETTLE_CYC+1).
- One sub-module, rca_core: purely combinational, parameter WIDTH, ports (sum, c_out, a, b, c_in). It is a generate chain of gate-level full-adder cells. It holds no state and no timing assumptions; the stage owns all timing.

## Test plan
- Add: WIDTH=4, SETTLE_CYC=3, a=3, b=5, c_in=0, acc_en=0 -> out_valid 3 edges after accept; sum=8, c_out=0, ovf=1.
- Carry-out: a=15, b=1, c_in=0 -> sum=0, c_out=1, ovf=0.
- Carry-in: a=7, b=0, c_in=1 -> sum=8, c_out=0, ovf=1.
- Accumulate: a=2, b=0 (acc_en=0), then b=3 (acc_en=1), then b=4 (acc_en=1) -> sums 2, 5, 9; the third has ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid with in_valid=1 and a, b toggling -> sum, c_out, ovf and in_ready=0 all stable. On out_ready=1, the next edge returns to IDLE and the next accept occurs one cycle later.
- Reset during SETTLE: pulse rst_n low asynchronously in mid-count -> all outputs 0 immediately; in_ready=1 after release; a following acc_en=1, b=6 gives sum=6.
